// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Latency: none (types only).
// Backpressure: n/a.
package rf_pkg;

   localparam int RF_ADDR_W   = 4;
   localparam int RF_DATA_W   = 16;
   localparam int RF_NUM_REGS = 16;
   localparam int RF_ZERO_REG = 0;

   // One pending writeback: destination register index and write data.
   typedef struct packed {
      logic [RF_ADDR_W-1:0] reg_idx;
      logic [RF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of both writeback request channels plus the register-file write port.
// Latency: none (wires only).
// Backpressure: reqN_ready is driven by the slave (arbiter) side.
interface rf_wb_arbiter_if #(
   parameter int ADDR_W = rf_pkg::RF_ADDR_W,
   parameter int DATA_W = rf_pkg::RF_DATA_W
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic [ADDR_W-1:0]    req0_reg;
   logic [DATA_W-1:0]    req0_data;
   logic                 req1_valid;
   logic                 req1_ready;
   logic [ADDR_W-1:0]    req1_reg;
   logic [DATA_W-1:0]    req1_data;
   logic                 rf_write_en;
   logic [ADDR_W-1:0]    rf_write_reg;
   logic [DATA_W-1:0]    rf_write_data;
   logic [2**ADDR_W-1:0] busy;
   logic                 idle;

   // Requester / register-file side.
   modport master (
      output req0_valid, req0_reg, req0_data,
      output req1_valid, req1_reg, req1_data,
      input  req0_ready, req1_ready,
      input  rf_write_en, rf_write_reg, rf_write_data, busy, idle
   );

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_reg, req0_data,
      input  req1_valid, req1_reg, req1_data,
      output req0_ready, req1_ready,
      output rf_write_en, rf_write_reg, rf_write_data, busy, idle
   );
endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Small per-requester writeback FIFO with a per-slot valid/register view for busy tracking.
// Latency: pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; full depends only on occupancy.
module wb_fifo #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push_i,
   input  logic [ADDR_W-1:0]             push_reg_i,
   input  logic [DATA_W-1:0]             push_data_i,
   input  logic                          pop_i,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [ADDR_W-1:0]             head_reg_o,
   output logic [DATA_W-1:0]             head_data_o,
   output logic [DEPTH-1:0]              ent_vld_o,
   output logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     count;
   logic              do_push, do_pop;
   logic [ADDR_W-1:0] reg_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   assign count   = wr_ptr_q - rd_ptr_q;
   assign full_o  = (count == PW'(DEPTH));
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign head_reg_o  = reg_mem[rd_ptr_q[AW-1:0]];
   assign head_data_o = data_mem[rd_ptr_q[AW-1:0]];

   // Pointer next-state: extra wrap bit distinguishes full from empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   // Pointer registers, cleared immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: slots are only read once the pointers mark them valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         reg_mem[wr_ptr_q[AW-1:0]]  <= push_reg_i;
         data_mem[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      ent_vld_o = '0;
      ent_reg_o = '0;
      for (int s = 0; s < DEPTH; s++) begin
         ent_vld_o[s] = ({1'b0, AW'(AW'(s) - rd_ptr_q[AW-1:0])} < count);
         ent_reg_o[s] = reg_mem[s];
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates two writeback FIFOs onto the single register-file write port; busy flags pending writes.
// Latency: one cycle accept-to-drive on rf_write_* when uncontended; one write committed per cycle.
// Backpressure: reqN_ready = !fullN. Optional RF_WB_RR_ARB_EN selects round-robin ties (default: requester 1 wins).
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input logic           clk,
   input logic           rst,
   rf_wb_arbiter_if.slave bus
);
   localparam int NREGS = 2**ADDR_W;

   logic                         full0, empty0, full1, empty1;
   logic                         push0, push1;
   logic                         gnt0, gnt1;
   logic                         prefer1;
   logic [ADDR_W-1:0]            head0_reg, head1_reg;
   logic [DATA_W-1:0]            head0_data, head1_data;
   logic [DEPTH-1:0]             ent0_vld, ent1_vld;
   logic [DEPTH-1:0][ADDR_W-1:0] ent0_reg, ent1_reg;

   logic                         wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]            wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]            wr_data_q, wr_data_d;
   logic [NREGS-1:0]             busy_c;

   // Writes to R0 complete the handshake but are never queued.
   assign bus.req0_ready = !full0;
   assign bus.req1_ready = !full1;
   assign push0 = bus.req0_valid && !full0 && (bus.req0_reg != ADDR_W'(RF_ZERO_REG));
   assign push1 = bus.req1_valid && !full1 && (bus.req1_reg != ADDR_W'(RF_ZERO_REG));

   wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo0 (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push0),
      .push_reg_i  (bus.req0_reg),
      .push_data_i (bus.req0_data),
      .pop_i       (gnt0),
      .full_o      (full0),
      .empty_o     (empty0),
      .head_reg_o  (head0_reg),
      .head_data_o (head0_data),
      .ent_vld_o   (ent0_vld),
      .ent_reg_o   (ent0_reg)
   );

   wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo1 (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push1),
      .push_reg_i  (bus.req1_reg),
      .push_data_i (bus.req1_data),
      .pop_i       (gnt1),
      .full_o      (full1),
      .empty_o     (empty1),
      .head_reg_o  (head1_reg),
      .head_data_o (head1_data),
      .ent_vld_o   (ent1_vld),
      .ent_reg_o   (ent1_reg)
   );

`ifdef RF_WB_RR_ARB_EN
   logic last_q, last_d;

   // Tie winner is whichever requester was not granted on the last contested cycle.
   assign prefer1 = !last_q;

   // Last-grant pointer moves only when both heads competed.
   always_comb begin
      last_d = last_q;
      if (!empty0 && !empty1) last_d = gnt1;
   end

   // Reset to "last grant = 1" so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= 1'b1;
      else     last_q <= last_d;
   end
`else
   assign prefer1 = 1'b1;
`endif

   // Grant a single head per cycle; ties resolved by prefer1.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!empty1 && (empty0 || prefer1)) gnt1 = 1'b1;
      else if (!empty0)                   gnt0 = 1'b1;
   end

   // Output next-state: load the popped entry, otherwise hold reg/data and drop enable.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      if (gnt1) begin
         wr_en_d   = 1'b1;
         wr_reg_d  = head1_reg;
         wr_data_d = head1_data;
      end else if (gnt0) begin
         wr_en_d   = 1'b1;
         wr_reg_d  = head0_reg;
         wr_data_d = head0_data;
      end
   end

   // Registered write port; reset drops any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Busy covers every queued entry plus the write currently on the port.
   always_comb begin
      busy_c = '0;
      for (int s = 0; s < DEPTH; s++) begin
         if (ent0_vld[s]) busy_c[ent0_reg[s]] = 1'b1;
         if (ent1_vld[s]) busy_c[ent1_reg[s]] = 1'b1;
      end
      if (wr_en_q) busy_c[wr_reg_q] = 1'b1;
   end

   assign bus.rf_write_en   = wr_en_q;
   assign bus.rf_write_reg  = wr_reg_q;
   assign bus.rf_write_data = wr_data_q;
   assign bus.busy          = busy_c;
   assign bus.idle          = empty0 && empty1 && !wr_en_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, R0 drop, contention, backpressure, mid-run reset.
// Inputs are driven and outputs sampled on the falling edge.
// Expected values are hand-derived per step; ties follow RF_WB_RR_ARB_EN when defined.
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter_if #(.ADDR_W(RF_ADDR_W), .DATA_W(RF_DATA_W)) bus ();

   rf_wb_arbiter #(.DEPTH(2), .DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive0(input logic v, input wb_entry_t e);
      bus.req0_valid = v;
      bus.req0_reg   = e.reg_idx;
      bus.req0_data  = e.data;
   endtask

   task automatic drive1(input logic v, input wb_entry_t e);
      bus.req1_valid = v;
      bus.req1_reg   = e.reg_idx;
      bus.req1_data  = e.data;
   endtask

   // Expected commit order for the contention step.
   logic [3:0]  ord_reg  [4];
   logic [15:0] ord_data [4];

   initial begin
      int  v0, v1, c0, c1;
      logic adv0, adv1;

`ifdef RF_WB_RR_ARB_EN
      ord_reg  = '{4'd1, 4'd5, 4'd2, 4'd6};
      ord_data = '{16'h1111, 16'h5555, 16'h2222, 16'h6666};
`else
      ord_reg  = '{4'd5, 4'd6, 4'd1, 4'd2};
      ord_data = '{16'h5555, 16'h6666, 16'h1111, 16'h2222};
`endif
      drive0(1'b0, '0);
      drive1(1'b0, '0);

      // Reset state.
      @(negedge clk);
      chk("rst_en",     bus.rf_write_en, 0);
      chk("rst_reg",    bus.rf_write_reg, 0);
      chk("rst_data",   bus.rf_write_data, 0);
      chk("rst_busy",   bus.busy, 0);
      chk("rst_idle",   bus.idle, 1);
      chk("rst_rdy0",   bus.req0_ready, 1);
      chk("rst_rdy1",   bus.req1_ready, 1);
      rst = 1'b0;

      // Single write from requester 0.
      drive0(1'b1, '{reg_idx: 4'd3, data: 16'hBEEF});
      chk("single_rdy0", bus.req0_ready, 1);
      step();
      drive0(1'b0, '0);
      chk("single_q_en",   bus.rf_write_en, 0);
      chk("single_q_busy", bus.busy, 16'h0008);
      chk("single_q_idle", bus.idle, 0);
      step();
      chk("single_en",   bus.rf_write_en, 1);
      chk("single_reg",  bus.rf_write_reg, 3);
      chk("single_data", bus.rf_write_data, 16'hBEEF);
      chk("single_busy", bus.busy, 16'h0008);
      step();
      chk("single_done_en",   bus.rf_write_en, 0);
      chk("single_done_busy", bus.busy, 0);
      chk("single_done_idle", bus.idle, 1);
      chk("single_hold_data", bus.rf_write_data, 16'hBEEF);

      // R0 write is accepted but dropped.
      drive1(1'b1, '{reg_idx: 4'd0, data: 16'h1234});
      chk("r0_rdy1", bus.req1_ready, 1);
      step();
      drive1(1'b0, '0);
      chk("r0_en1",   bus.rf_write_en, 0);
      chk("r0_busy1", bus.busy, 0);
      chk("r0_idle1", bus.idle, 1);
      step();
      chk("r0_en2",   bus.rf_write_en, 0);
      chk("r0_data",  bus.rf_write_data, 16'hBEEF);

      // Contention: two entries per requester pushed together.
      drive0(1'b1, '{reg_idx: 4'd1, data: 16'h1111});
      drive1(1'b1, '{reg_idx: 4'd5, data: 16'h5555});
      step();
      drive0(1'b1, '{reg_idx: 4'd2, data: 16'h2222});
      drive1(1'b1, '{reg_idx: 4'd6, data: 16'h6666});
      chk("cont_rdy0", bus.req0_ready, 1);
      chk("cont_rdy1", bus.req1_ready, 1);
      step();
      drive0(1'b0, '0);
      drive1(1'b0, '0);
      chk("cont_busy", bus.busy, 16'h0066);
`ifdef RF_WB_RR_ARB_EN
      chk("cont_full0", bus.req0_ready, 1);
      chk("cont_full1", bus.req1_ready, 0);
`else
      chk("cont_full0", bus.req0_ready, 0);
      chk("cont_full1", bus.req1_ready, 1);
`endif
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("cont_en%0d", i),   bus.rf_write_en, 1);
         chk($sformatf("cont_reg%0d", i),  bus.rf_write_reg, ord_reg[i]);
         chk($sformatf("cont_data%0d", i), bus.rf_write_data, ord_data[i]);
         step();
      end
      chk("cont_end_en",   bus.rf_write_en, 0);
      chk("cont_end_idle", bus.idle, 1);

      // Backpressure: req0 (reg 9, data 1..4) against a steady req1 stream (reg 7, 0x101..0x106).
      v0 = 1; v1 = 1; c0 = 0; c1 = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (bus.rf_write_en) begin
            if (bus.rf_write_reg == 4'd9) begin
               c0++;
               chk("bp_ord0", bus.rf_write_data, c0);
            end else begin
               c1++;
               chk("bp_ord1", {bus.rf_write_reg, bus.rf_write_data}, {4'd7, 16'h100 + 16'(c1)});
            end
         end
`ifndef RF_WB_RR_ARB_EN
         if (cyc == 2) begin
            chk("bp_full_rdy0", bus.req0_ready, 0);
            chk("bp_accepts0",  v0, 3);
         end
`endif
         drive0(v0 <= 4, '{reg_idx: 4'd9, data: 16'(v0)});
         drive1(v1 <= 6, '{reg_idx: 4'd7, data: 16'h100 + 16'(v1)});
         adv0 = bus.req0_valid && bus.req0_ready;
         adv1 = bus.req1_valid && bus.req1_ready;
         step();
         if (adv0) v0++;
         if (adv1) v1++;
      end
      drive0(1'b0, '0);
      drive1(1'b0, '0);
      chk("bp_count0", c0, 4);
      chk("bp_count1", c1, 6);
      chk("bp_idle",   bus.idle, 1);

      // Asynchronous reset with both FIFOs loaded.
      drive0(1'b1, '{reg_idx: 4'd10, data: 16'hAAAA});
      drive1(1'b1, '{reg_idx: 4'd12, data: 16'hCCCC});
      step();
      drive0(1'b1, '{reg_idx: 4'd11, data: 16'hBBBB});
      drive1(1'b1, '{reg_idx: 4'd13, data: 16'hDDDD});
      step();
      drive0(1'b0, '0);
      drive1(1'b0, '0);
      chk("mid_pre_idle", bus.idle, 0);
      chk("mid_pre_en",   bus.rf_write_en, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_en",   bus.rf_write_en, 0);
      chk("mid_reg",  bus.rf_write_reg, 0);
      chk("mid_data", bus.rf_write_data, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_idle", bus.idle, 1);
      chk("mid_rdy0", bus.req0_ready, 1);
      chk("mid_rdy1", bus.req1_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_en1",   bus.rf_write_en, 0);
      chk("post_idle1", bus.idle, 1);
      step();
      chk("post_en2",   bus.rf_write_en, 0);
      chk("post_busy2", bus.busy, 0);
      chk("post_idle2", bus.idle, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
